uart_tx: RTL and testbench



---
 rtl/uart_tx_if.sv | 10 +
 rtl/uart_tx.sv | 90 +++++++++
 tb/tb_uart_tx.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake and serial line bundle for uart_tx
interface uart_tx_if;
  logic [7:0] din;
  logic       din_vld;
  logic       din_rdy;
  logic       tx;
  logic       busy;
  modport master (output din, din_vld, input din_rdy, tx, busy);
  modport slave  (input din, din_vld, output din_rdy, tx, busy);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8-bit LSB-first serialiser with holding register, optional parity and 1/2 stop bits
module uart_tx #(
  parameter int BAUD_DIV  = 5208,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_tx_if.slave  bus
);
  localparam int CW = $clog2(BAUD_DIV);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d, hold_q, hold_d;
  logic          full_q, full_d, par_q, par_d, tx_q, tx_d, busy_q, busy_d;
  logic          bit_end, xfer, load;
  assign bit_end     = cnt_q == CW'(BAUD_DIV - 1);
  assign load        = bus.din_vld && !full_q;
  assign bus.din_rdy = ~full_q;
  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  // next state; tx/busy are derived from the next state so the registered outputs line up with it
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    xfer    = 1'b0;
    case (state_q)
      IDLE:  xfer = full_q;
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA:  if (bit_end) begin
        shift_d = shift_q >> 1;
        idx_d   = idx_q + 1'b1;
        if (idx_q == 3'd7) state_d = (PARITY != 0) ? PAR : STOP;
      end
      PAR:   if (bit_end) begin
        state_d = STOP;
        idx_d   = '0;
      end
      STOP:  if (bit_end) begin
        idx_d = idx_q + 1'b1;
        if (idx_q == 3'(STOP_BITS - 1)) begin
          state_d = IDLE;
          xfer    = full_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (xfer) begin
      state_d = START;
      shift_d = hold_q;
      par_d   = ^hold_q ^ (PARITY == 2);
    end
    full_d = xfer ? 1'b0 : load ? 1'b1 : full_q;
    hold_d = load ? bus.din : hold_q;
    tx_d   = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PAR ? par_d : 1'b1;
    busy_d = state_d != IDLE || full_d;
  end
  // state and output registers, synchronous active-low reset aborts any frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx across parity/stop configurations
module tb_uart_tx;
  logic       clk = 1'b0, rst_n = 1'b0, din_vld = 1'b0;
  logic [7:0] din = 8'h00;
  int         sel = 0, cyc = 0, n_chk = 0, n_fail = 0;
  bit         abort = 1'b0;
  logic [7:0] exp_q[$];
  int         starts[$];
  int         par_c[4]  = '{0, 1, 2, 0};
  int         stop_c[4] = '{1, 1, 1, 2};
  logic       tx_m, rdy_m, busy_m;

  uart_tx_if u0 (), u1 (), u2 (), u3 ();
  assign u0.din = din;
  assign u1.din = din;
  assign u2.din = din;
  assign u3.din = din;
  assign u0.din_vld = din_vld && sel == 0;
  assign u1.din_vld = din_vld && sel == 1;
  assign u2.din_vld = din_vld && sel == 2;
  assign u3.din_vld = din_vld && sel == 3;
  assign tx_m   = sel == 0 ? u0.tx      : sel == 1 ? u1.tx      : sel == 2 ? u2.tx      : u3.tx;
  assign rdy_m  = sel == 0 ? u0.din_rdy : sel == 1 ? u1.din_rdy : sel == 2 ? u2.din_rdy : u3.din_rdy;
  assign busy_m = sel == 0 ? u0.busy    : sel == 1 ? u1.busy    : sel == 2 ? u2.busy    : u3.busy;

  uart_tx #(.BAUD_DIV(16), .PARITY(0), .STOP_BITS(1)) d0 (.clk(clk), .rst_n(rst_n), .bus(u0));
  uart_tx #(.BAUD_DIV(16), .PARITY(1), .STOP_BITS(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(u1));
  uart_tx #(.BAUD_DIV(16), .PARITY(2), .STOP_BITS(1)) d2 (.clk(clk), .rst_n(rst_n), .bus(u2));
  uart_tx #(.BAUD_DIV(16), .PARITY(0), .STOP_BITS(2)) d3 (.clk(clk), .rst_n(rst_n), .bus(u3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int flen(input int s);
    return 16 * (9 + ((par_c[s] != 0) ? 1 : 0) + stop_c[s]);
  endfunction

  task automatic step(output bit h);
    h = din_vld && rdy_m && rst_n;
    if (h) exp_q.push_back(din);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    bit h = 1'b0;
    int n = 0;
    din = b;
    din_vld = 1'b1;
    while (!h && n < 2000) begin
      step(h);
      n++;
    end
    din_vld = 1'b0;
    chk("handshake_done", h, 1);
    chk("rdy_after_hs", rdy_m, 0);
    chk("busy_after_hs", busy_m, 1);
  endtask

  task automatic send_idle(input logic [7:0] b);
    bit h;
    send(b);
    chk("tx_before_start", tx_m, 1);
    step(h);
    chk("start_latency", tx_m, 0);
  endtask

  task automatic wait_idle();
    bit h;
    int n = 0;
    while (busy_m && n < 5000) begin
      step(h);
      n++;
    end
    chk("idle_reached", busy_m, 0);
    chk("idle_tx", tx_m, 1);
    chk("frame_len", cyc - starts[$], flen(sel));
  endtask

  initial begin : mon
    logic [7:0] b;
    logic       e, g;
    int         p, nb;
    forever begin
      @(negedge clk);
      if (!abort && rst_n && tx_m === 1'b0) begin
        starts.push_back(cyc);
        chk("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          b  = exp_q.pop_front();
          p  = par_c[sel];
          nb = 9 + ((p != 0) ? 1 : 0) + stop_c[sel];
          for (int i = 0; i < nb && !abort; i++) begin
            e = i == 0 ? 1'b0 : i <= 8 ? b[i-1] : (p != 0 && i == 9) ? (p == 1 ? ^b : ~^b) : 1'b1;
            g = e;
            for (int k = 0; k < 16 && !abort; k++) begin
              if (i != 0 || k != 0) @(negedge clk);
              if (!abort && tx_m !== e) g = tx_m;
            end
            if (!abort) chk($sformatf("byte%02h_bit%0d", b, i), g, e);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         h;
    int         n, lows, nhs;
    logic [7:0] seq[3];
    seq = '{8'h01, 8'h80, 8'hFF};
    din = 8'hAA;
    din_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(h);
      chk("rst_tx", tx_m, 1);
      chk("rst_rdy", rdy_m, 1);
      chk("rst_busy", busy_m, 0);
    end
    rst_n = 1'b1;
    din_vld = 1'b0;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      step(h);
      if (tx_m !== 1'b1) lows++;
    end
    chk("post_rst_idle", lows, 0);
    send_idle(8'h55);
    wait_idle();
    sel = 1;
    send_idle(8'hA5);
    wait_idle();
    send_idle(8'h07);
    wait_idle();
    sel = 2;
    send_idle(8'h07);
    wait_idle();
    sel = 3;
    n = 0;
    nhs = 0;
    din = seq[0];
    din_vld = 1'b1;
    while (nhs < 3 && n < 2000) begin
      step(h);
      n++;
      if (h) begin
        nhs++;
        chk("b2b_rdy_low", rdy_m, 0);
        if (nhs < 3) din = seq[nhs];
        else din_vld = 1'b0;
      end
    end
    din_vld = 1'b0;
    chk("b2b_handshakes", nhs, 3);
    wait_idle();
    chk("b2b_gap1", starts[$-1] - starts[$-2], 176);
    chk("b2b_gap2", starts[$] - starts[$-1], 176);
    sel = 0;
    send_idle(8'h35);
    send(8'hE7);
    n = 0;
    while (n < 1000 && cyc != starts[$] + 70) begin
      step(h);
      n++;
    end
    chk("reach_data_bit3", cyc - starts[$], 70);
    chk("pre_rst_tx", tx_m, 0);
    abort = 1'b1;
    rst_n = 1'b0;
    step(h);
    chk("midrst_tx", tx_m, 1);
    chk("midrst_rdy", rdy_m, 1);
    chk("midrst_busy", busy_m, 0);
    exp_q.delete();
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      step(h);
      if (tx_m !== 1'b1) lows++;
    end
    chk("queued_byte_dropped", lows, 0);
    chk("midrst_idle_busy", busy_m, 0);
    abort = 1'b0;
    send_idle(8'hC3);
    send(8'h5A);
    nhs = 0;
    din_vld = 1'b1;
    for (int i = 0; i < 40; i++) begin
      din = 8'($urandom);
      step(h);
      if (h) nhs++;
    end
    din_vld = 1'b0;
    chk("stall_no_handshake", nhs, 0);
    wait_idle();
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
